// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the multi-mode SPI controller.
//   spi_state_e : frame FSM states (IDLE, SETUP, SHIFT, HOLD)
//   TX_FLAG_W   : number of control bits stored next to each TX data word
//   tx_entry_w(): width of one TX FIFO entry {ignore, data}. The entry
//                 struct itself depends on DATA_W, so it is declared in the
//                 top module; this function keeps its width in one place.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    localparam int TX_FLAG_W = 1;

    function automatic int tx_entry_w(input int data_w);
        return data_w + TX_FLAG_W;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// -----------------------------------------------------------------------------
// spi_sync_fifo
// Single-clock FIFO with registered empty/full flags and a show-ahead head.
//   clk, rst_n : clock, synchronous active-low reset (clears pointers only)
//   push, din  : write request and data; ignored when full unless a pop
//                happens in the same cycle
//   pop        : read request; ignored when empty
//   head       : entry at the read pointer (valid while !empty)
//   empty,full : registered flags describing the state after the last edge
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        do_pop   = pop && !empty_q;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/spi_controller_mc.sv
// -----------------------------------------------------------------------------
// spi_controller_mc
// FIFO-buffered SPI master with programmable word width, SCK divider,
// CPOL/CPHA mode and chip select.
//   clk, rst_n            : clock, synchronous active-low reset
//   wr, din,
//   ignore_response       : push {ignore_response, din} into the TX FIFO
//   rd, dout              : pop the RX FIFO into registered dout
//   data_avail            : RX FIFO not empty
//   tx_empty, tx_full     : TX FIFO flags
//   rx_overflow           : one-cycle pulse when a response was dropped
//   busy                  : frame in progress
//   cfg_cpol, cfg_cpha,
//   cfg_div, cfg_cs_sel   : mode, SCK half-period (cfg_div+1 clk) and target,
//                           captured when a frame starts from IDLE
//   cs_n, sck, mosi, miso : SPI bus (MSB first)
// Consecutive words to the same chip select run without releasing cs_n.
// -----------------------------------------------------------------------------
module spi_controller_mc
    import spi_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int NUM_CS     = 4,
    parameter  int DIV_W      = 16,
    localparam int SEL_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              ignore_response,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              data_avail,
    output logic              tx_empty,
    output logic              tx_full,
    output logic              rx_overflow,
    output logic              busy,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [SEL_W-1:0]  cfg_cs_sel,
    output logic [NUM_CS-1:0] cs_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    localparam int TX_W   = tx_entry_w(DATA_W);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef struct packed {
        logic              ignore;
        logic [DATA_W-1:0] data;
    } tx_entry_t;

    spi_state_e        state_q, state_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              ign_q, ign_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    tx_entry_t         tx_wr_entry, tx_head;
    logic [TX_W-1:0]   tx_head_raw;
    logic              tx_pop, tx_empty_w, tx_full_w;
    logic [DATA_W-1:0] rx_head;
    logic              rx_push, rx_pop, rx_empty_w, rx_full_w;
    logic              half_done, leading, sample_edge;

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        // An out-of-range index matches no line, so nothing is selected.
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    assign tx_wr_entry = '{ignore: ignore_response, data: din};
    assign tx_head     = tx_entry_t'(tx_head_raw);

    spi_sync_fifo #(.WIDTH(TX_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr),
        .din   (tx_wr_entry),
        .pop   (tx_pop),
        .head  (tx_head_raw),
        .empty (tx_empty_w),
        .full  (tx_full_w)
    );

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_sh_q),
        .pop   (rx_pop),
        .head  (rx_head),
        .empty (rx_empty_w),
        .full  (rx_full_w)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch
        // can leave a signal unassigned and infer a latch.
        state_d   = state_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        div_d     = div_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        ign_d     = ign_q;
        rx_ovf_d  = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        rx_pop    = rd && !rx_empty_w;
        dout_d    = rx_pop ? rx_head : dout_q;
        half_done = (cnt_q == '0);
        // edge_q counts completed edges, so the upcoming edge is odd (leading)
        // when edge_q is even.
        leading     = !edge_q[0];
        sample_edge = leading ^ cpha_q;

        case (state_q)
            IDLE: begin
                sck_d  = cfg_cpol;
                cs_n_d = '1;
                if (!tx_empty_w) begin
                    tx_pop  = 1'b1;
                    cpol_d  = cfg_cpol;
                    cpha_d  = cfg_cpha;
                    div_d   = cfg_div;
                    sel_d   = cfg_cs_sel;
                    cs_n_d  = cs_decode(cfg_cs_sel);
                    ign_d   = tx_head.ignore;
                    edge_d  = '0;
                    cnt_d   = cfg_div;
                    // CPHA=0 presents the MSB now; the shifter then holds the
                    // remaining bits. CPHA=1 drives the MSB on the first edge.
                    tx_sh_d = cfg_cpha ? tx_head.data : (tx_head.data << 1);
                    if (!cfg_cpha) mosi_d = tx_head.data[DATA_W-1];
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (half_done) begin
                    cnt_d   = div_q;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            SHIFT: begin
                if (half_done) begin
                    cnt_d = div_q;
                    sck_d = ~sck_q;
                    if (sample_edge) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    end else begin
                        mosi_d  = tx_sh_q[DATA_W-1];
                        tx_sh_d = tx_sh_q << 1;
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end else begin
                        edge_d = edge_q + EDGE_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            HOLD: begin
                sck_d = cpol_q;
                if (half_done) begin
                    rx_push  = !ign_q;
                    rx_ovf_d = !ign_q && rx_full_w && !rx_pop;
                    if (!tx_empty_w && (cfg_cs_sel == sel_q)) begin
                        // Continue on the same CS with the mode captured at
                        // frame start.
                        tx_pop  = 1'b1;
                        ign_d   = tx_head.ignore;
                        edge_d  = '0;
                        cnt_d   = div_q;
                        tx_sh_d = cpha_q ? tx_head.data : (tx_head.data << 1);
                        if (!cpha_q) mosi_d = tx_head.data[DATA_W-1];
                        state_d = SHIFT;
                    end else begin
                        cs_n_d  = '1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            default: begin
                cs_n_d  = '1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= '1;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            ign_q    <= 1'b0;
            rx_ovf_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            div_q    <= div_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
            ign_q    <= ign_d;
            rx_ovf_q <= rx_ovf_d;
            dout_q   <= dout_d;
        end
    end

    assign dout        = dout_q;
    assign data_avail  = !rx_empty_w;
    assign tx_empty    = tx_empty_w;
    assign tx_full     = tx_full_w;
    assign rx_overflow = rx_ovf_q;
    assign busy        = (state_q != IDLE);
    assign cs_n        = cs_n_q;
    assign sck         = sck_q;
    assign mosi        = mosi_q;

endmodule

// File: tb/tb_spi_controller_mc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_controller_mc
// Directed bench: a behavioural SPI slave returns words from a response
// table and captures MOSI words; checks cover reset, modes 0 and 3,
// back-to-back CS hold, response discard, TX fill, RX overflow and reset
// in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_spi_controller_mc;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int NCS   = 4;
    localparam int DW    = 16;

    logic           clk;
    logic           rst_n;
    logic           wr;
    logic [W-1:0]   din;
    logic           ignore_response;
    logic           rd;
    logic [W-1:0]   dout;
    logic           data_avail;
    logic           tx_empty;
    logic           tx_full;
    logic           rx_overflow;
    logic           busy;
    logic           cfg_cpol;
    logic           cfg_cpha;
    logic [DW-1:0]  cfg_div;
    logic [1:0]     cfg_cs_sel;
    logic [NCS-1:0] cs_n;
    logic           sck;
    logic           mosi;
    logic           miso;

    spi_controller_mc #(
        .DATA_W(W), .FIFO_DEPTH(DEPTH), .NUM_CS(NCS), .DIV_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .din(din),
        .ignore_response(ignore_response), .rd(rd), .dout(dout),
        .data_avail(data_avail), .tx_empty(tx_empty), .tx_full(tx_full),
        .rx_overflow(rx_overflow), .busy(busy), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_div(cfg_div), .cfg_cs_sel(cfg_cs_sel),
        .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- slave model / bus monitor ----------------
    logic [W-1:0]   resp_tbl [64];
    int             resp_base;
    logic           cs_act;
    assign cs_act = (cs_n != {NCS{1'b1}});

    logic           prev_sck, prev_act;
    int             sl_pos, sl_idx, cap_bits, cap_n, rise_cnt, rel_cnt;
    logic [W-1:0]   sl_sh, cap_sh;
    logic [W-1:0]   cap_words [64];
    logic [NCS-1:0] cs_at_rise;
    time            last_rise, rise_period;

    initial begin : slave
        miso = 1'b0; prev_sck = 1'b0; prev_act = 1'b0;
        sl_pos = 0; sl_idx = 0; cap_bits = 0; cap_n = 0;
        rise_cnt = 0; rel_cnt = 0; sl_sh = '0; cap_sh = '0;
        cs_at_rise = '1; last_rise = 0; rise_period = 0;
        forever begin
            @(sck or cs_act);
            if (cs_act === 1'b1 && prev_act !== 1'b1) begin
                sl_pos = 0; cap_bits = 0; sl_idx = resp_base;
                if (!cfg_cpha) begin
                    sl_sh = (sl_idx < 64) ? resp_tbl[sl_idx] : '0;
                    sl_idx++;
                    miso  = sl_sh[W-1];
                    sl_sh = sl_sh << 1;
                end
            end else if (cs_act === 1'b1 && sck !== prev_sck) begin
                sl_pos = (sl_pos % (2 * W)) + 1;
                if (sck === 1'b1) begin
                    rise_cnt++;
                    rise_period = $time - last_rise;
                    last_rise   = $time;
                    cs_at_rise  = cs_n;
                end
                if (((sl_pos % 2) == 1) != cfg_cpha) begin
                    cap_sh = {cap_sh[W-2:0], mosi};
                    cap_bits++;
                    if (cap_bits == W) begin
                        if (cap_n < 64) cap_words[cap_n] = cap_sh;
                        cap_n++;
                        cap_bits = 0;
                    end
                end else begin
                    if (sl_pos == 1 || sl_pos == 2 * W) begin
                        sl_sh = (sl_idx < 64) ? resp_tbl[sl_idx] : '0;
                        sl_idx++;
                    end
                    miso  = sl_sh[W-1];
                    sl_sh = sl_sh << 1;
                end
            end
            if (cs_act !== 1'b1 && prev_act === 1'b1) rel_cnt++;
            prev_sck = sck;
            prev_act = cs_act;
        end
    end

    int ovf_cnt;
    initial begin
        ovf_cnt = 0;
        forever begin
            @(negedge clk);
            if (rx_overflow === 1'b1) ovf_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at the next negedge (one-cycle strobe).
    task automatic push(input logic [W-1:0] d, input logic ign);
        wr = 1'b1; din = d; ignore_response = ign;
        @(negedge clk);
        wr = 1'b0; ignore_response = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [W-1:0] exp);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check(tag, 32'(dout), 32'(exp));
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((busy || !tx_empty) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha,
                           input logic [DW-1:0] div, input logic [1:0] sel);
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_div = div; cfg_cs_sel = sel;
        @(negedge clk);
        @(negedge clk);
    endtask

    int r0, c0, rel0, o0, n;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; wr = 1'b0; din = '0; ignore_response = 1'b0; rd = 1'b0;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 16'd1; cfg_cs_sel = 2'd0;
        for (int i = 0; i < 64; i++) resp_tbl[i] = '0;
        resp_tbl[0] = 8'h3C;
        resp_tbl[1] = 8'h5A; resp_tbl[2] = 8'hC3;
        resp_tbl[3] = 8'h99; resp_tbl[4] = 8'h66;
        for (int i = 0; i < 17; i++) resp_tbl[5 + i] = 8'(8'hB0 + i);
        resp_base = 0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_cs_n",   32'(cs_n), 32'hF);
        check("rst_sck",    32'(sck), 32'd0);
        check("rst_mosi",   32'(mosi), 32'd0);
        check("rst_dout",   32'(dout), 32'd0);
        check("rst_flags",  32'({tx_empty, tx_full, data_avail, rx_overflow, busy}), 32'b10000);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- mode 0, div 1, sel 0: 0xA5 out, 0x3C back ----
        set_cfg(1'b0, 1'b0, 16'd1, 2'd0);
        resp_base = 0; r0 = rise_cnt; c0 = cap_n;
        push(8'hA5, 1'b0);
        wait_done("m0_done", 200);
        check("m0_rises",  32'(rise_cnt - r0), 32'd8);
        check("m0_period", 32'(rise_period), 32'd40);
        check("m0_cs",     32'(cs_at_rise), 32'hE);
        check("m0_mosi",   32'(cap_words[c0]), 32'hA5);
        check("m0_avail",  32'(data_avail), 32'd1);
        pop_check("m0_dout", 8'h3C);
        check("m0_empty",  32'(data_avail), 32'd0);

        // ---- mode 3, div 0, back-to-back ----
        set_cfg(1'b1, 1'b1, 16'd0, 2'd0);
        check("m3_idle_sck", 32'(sck), 32'd1);
        resp_base = 1; r0 = rise_cnt; c0 = cap_n; rel0 = rel_cnt;
        push(8'h81, 1'b0);
        push(8'h7E, 1'b0);
        wait_done("m3_done", 200);
        check("m3_cs_release", 32'(rel_cnt - rel0), 32'd1);
        check("m3_rises",  32'(rise_cnt - r0), 32'd16);
        check("m3_period", 32'(rise_period), 32'd20);
        check("m3_mosi0",  32'(cap_words[c0]), 32'h81);
        check("m3_mosi1",  32'(cap_words[c0 + 1]), 32'h7E);
        check("m3_sck_end", 32'(sck), 32'd1);
        pop_check("m3_rx0", 8'h5A);
        pop_check("m3_rx1", 8'hC3);
        check("m3_empty", 32'(data_avail), 32'd0);

        // ---- ignore flag, mode 0, sel 1 ----
        set_cfg(1'b0, 1'b0, 16'd1, 2'd1);
        resp_base = 3; c0 = cap_n;
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        wait_done("ign_done", 300);
        check("ign_cs",    32'(cs_at_rise), 32'hD);
        check("ign_mosi0", 32'(cap_words[c0]), 32'h11);
        check("ign_mosi1", 32'(cap_words[c0 + 1]), 32'h22);
        pop_check("ign_rx", 8'h66);
        check("ign_one_word", 32'(data_avail), 32'd0);

        // ---- TX fill and RX overflow, div 2, sel 2 ----
        set_cfg(1'b0, 1'b0, 16'd2, 2'd2);
        resp_base = 5; c0 = cap_n; o0 = ovf_cnt;
        push(8'h40, 1'b0);
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        check("fill_start", 32'(n < 50), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            push(8'(8'h40 + i), 1'b0);
            if (i == DEPTH - 1) check("fill_not_full", 32'(tx_full), 32'd0);
        end
        check("fill_full", 32'(tx_full), 32'd1);
        push(8'hEE, 1'b0);
        check("fill_still_full", 32'(tx_full), 32'd1);
        wait_done("fill_done", 3000);
        check("fill_words", 32'(cap_n - c0), 32'd17);
        check("fill_last",  32'(cap_words[c0 + 16]), 32'h50);
        check("fill_cs",    32'(cs_at_rise), 32'hB);
        check("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            rd = 1'b1;
            @(negedge clk);
            check($sformatf("ovf_rx%0d", i), 32'(dout), 32'(resp_tbl[5 + i]));
        end
        rd = 1'b0;
        check("ovf_drained", 32'(data_avail), 32'd0);
        pop_check("rd_empty_hold", resp_tbl[5 + DEPTH - 1]);

        // ---- reset in the middle of a frame ----
        set_cfg(1'b0, 1'b0, 16'd1, 2'd0);
        resp_base = 40; r0 = rise_cnt;
        push(8'hF0, 1'b0);
        push(8'h0F, 1'b0);
        n = 0;
        while ((rise_cnt - r0) < 3 && n < 200) begin @(negedge clk); n++; end
        check("mid_reach_bit3", 32'(n < 200), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_cs_n",  32'(cs_n), 32'hF);
        check("mid_sck",   32'(sck), 32'd0);
        check("mid_flags", 32'({tx_empty, tx_full, data_avail, busy}), 32'b1000);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_no_rx", 32'({data_avail, busy}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
